// File: rtl/mem_pkg.sv
// Shared definitions for the data memory and its load/store front-end.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mau_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store front-end: one request at a time, drives the data memory pins
// directly and returns load data on a backpressured response channel.
//
// state | meaning
// IDLE  | ready for any request
// WAIT  | load issued, memory read data arrives this cycle
// RESP  | load data held on rsp_rdata until consumed
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  import mem_pkg::*;

  mau_state_t        r_state;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_load_count;
  logic [CNT_W-1:0]  r_store_count;

  mem_req_t          w_req;
  logic              w_req_ready;
  logic              w_accept;

  assign w_req.write = req_write;
  assign w_req.addr  = req_addr;
  assign w_req.wdata = req_wdata;

  // rst_n gates ready so the memory sees no strobes while reset is held
  assign w_req_ready = rst_n & ((r_state == IDLE) | ((r_state == RESP) & rsp_ready));
  assign w_accept    = req_valid & w_req_ready;

  assign req_ready   = w_req_ready;
  assign mem_wen     = w_accept & w_req.write;
  assign mem_ren     = w_accept & ~w_req.write;
  assign mem_addr    = w_req.addr;
  assign mem_wdata   = w_req.wdata;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rdata;
  assign load_count  = r_load_count;
  assign store_count = r_store_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rsp_valid   <= 1'b0;
      r_rdata       <= '0;
      r_load_count  <= '0;
      r_store_count <= '0;
    end else begin
      if (w_accept) begin
        if (w_req.write) r_store_count <= r_store_count + CNT_W'(1);
        else             r_load_count  <= r_load_count + CNT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_accept && !w_req.write) r_state <= WAIT;
        end
        WAIT: begin
          r_rdata     <= mem_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_accept && !w_req.write) r_state <= WAIT;
            else                          r_state <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
